// File: rtl/lamp_guard.sv
// lamp_guard: safety stage between the traffic light controller and the lamps.
// Build option: define LAMP_GUARD_CAUSE_EN to expose the latched fault_cause output.
//
// state    | meaning
// ST_PASS  | lamps follow the sampled request, safety rules checked every cycle
// ST_FAULT | fault latched, red/green dark, yellow flashing until a clear while dark
module lamp_guard #(
    parameter int MIN_DWELL   = 4,
    parameter int ILLEGAL_CYC = 2,
    parameter int FLASH_HALF  = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r_in,
    input  logic       y_in,
    input  logic       g_in,
    input  logic       fault_clr,
    output logic       lamp_r,
    output logic       lamp_y,
    output logic       lamp_g,
    output logic       fault
`ifdef LAMP_GUARD_CAUSE_EN
    ,
    output logic [1:0] fault_cause
`endif
);

    localparam logic [0:0] ST_PASS  = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [2:0] ENC_DARK  = 3'd0;
    localparam logic [2:0] ENC_R     = 3'd1;
    localparam logic [2:0] ENC_Y     = 3'd2;
    localparam logic [2:0] ENC_G     = 3'd3;
    localparam logic [2:0] ENC_MULTI = 3'd4;

    localparam logic [1:0] LL_NONE = 2'd0;
    localparam logic [1:0] LL_R    = 2'd1;
    localparam logic [1:0] LL_G    = 2'd3;

    localparam logic [1:0] CA_NONE  = 2'b00;
    localparam logic [1:0] CA_OVL   = 2'b01;
    localparam logic [1:0] CA_SEQ   = 2'b10;
    localparam logic [1:0] CA_DWELL = 2'b11;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] ILL_C   = CNT_W'(ILLEGAL_CYC);
    localparam logic [CNT_W-1:0] FLASH_C = CNT_W'(FLASH_HALF);

    logic [0:0]       r_state;
    logic             r_smp_r, r_smp_y, r_smp_g;
    logic             r_lamp_r, r_lamp_y, r_lamp_g, r_fault;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_multi;
    logic [CNT_W-1:0] r_flash;

    logic [2:0]       w_enc;
    logic             w_lit, w_change, w_seq_ok;
    logic             w_overlap, w_seq, w_dwell, w_det;
    logic [1:0]       w_next_col;
    logic [1:0]       w_cause;
    logic [CNT_W-1:0] w_multi_nxt;

    always_comb begin
        w_enc = ENC_MULTI;
        case ({r_smp_r, r_smp_y, r_smp_g})
            3'b000:  w_enc = ENC_DARK;
            3'b100:  w_enc = ENC_R;
            3'b010:  w_enc = ENC_Y;
            3'b001:  w_enc = ENC_G;
            default: w_enc = ENC_MULTI;
        endcase
    end

    // Lit colour codes R/Y/G are 1/2/3, so the legal successor is a wrap-around increment.
    assign w_lit       = (w_enc != ENC_DARK) && (w_enc != ENC_MULTI);
    assign w_change    = w_lit && (r_last != LL_NONE) && (r_last != w_enc[1:0]);
    assign w_next_col  = (r_last == LL_G) ? LL_R : r_last + 2'd1;
    assign w_seq_ok    = (w_enc[1:0] == w_next_col);
    assign w_multi_nxt = r_multi + 1'b1;

    assign w_overlap = (w_enc == ENC_MULTI) && (w_multi_nxt >= ILL_C);
    assign w_seq     = w_change && !w_seq_ok;
    assign w_dwell   = w_change && (r_dwell < MIN_C);

    always_comb begin
        w_cause = CA_NONE;
        if (w_overlap)    w_cause = CA_OVL;
        else if (w_seq)   w_cause = CA_SEQ;
        else if (w_dwell) w_cause = CA_DWELL;
    end

    assign w_det = (w_cause != CA_NONE);

`ifdef LAMP_GUARD_CAUSE_EN
    logic [1:0] r_cause;

    always_ff @(posedge clk) begin
        if (rst)                                                     r_cause <= CA_NONE;
        else if (r_state == ST_PASS && w_det)                        r_cause <= w_cause;
        else if (r_state == ST_FAULT && fault_clr && w_enc == ENC_DARK) r_cause <= CA_NONE;
    end

    assign fault_cause = r_cause;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_PASS;
            r_smp_r  <= 1'b0;
            r_smp_y  <= 1'b0;
            r_smp_g  <= 1'b0;
            r_lamp_r <= 1'b0;
            r_lamp_y <= 1'b0;
            r_lamp_g <= 1'b0;
            r_fault  <= 1'b0;
            r_last   <= LL_NONE;
            r_dwell  <= '0;
            r_multi  <= '0;
            r_flash  <= '0;
        end else begin
            r_smp_r <= r_in;
            r_smp_y <= y_in;
            r_smp_g <= g_in;
            if (r_state == ST_PASS) begin
                if (w_det) begin
                    r_state  <= ST_FAULT;
                    r_fault  <= 1'b1;
                    r_lamp_r <= 1'b0;
                    r_lamp_g <= 1'b0;
                    r_lamp_y <= 1'b1;
                    r_flash  <= FLASH_C - 1'b1;
                end else if (w_enc == ENC_DARK) begin
                    r_lamp_r <= 1'b0;
                    r_lamp_y <= 1'b0;
                    r_lamp_g <= 1'b0;
                    r_last   <= LL_NONE;
                    r_dwell  <= '0;
                    r_multi  <= '0;
                end else if (w_enc == ENC_MULTI) begin
                    r_multi <= w_multi_nxt;
                end else begin
                    r_lamp_r <= (w_enc == ENC_R);
                    r_lamp_y <= (w_enc == ENC_Y);
                    r_lamp_g <= (w_enc == ENC_G);
                    r_multi  <= '0;
                    r_last   <= w_enc[1:0];
                    if (w_enc[1:0] == r_last)
                        r_dwell <= (r_dwell >= MIN_C) ? r_dwell : r_dwell + 1'b1;
                    else
                        r_dwell <= CNT_W'(1);
                end
            end else begin
                // A clear only counts while the sampled request is dark; it is not remembered.
                if (fault_clr && w_enc == ENC_DARK) begin
                    r_state  <= ST_PASS;
                    r_fault  <= 1'b0;
                    r_lamp_r <= 1'b0;
                    r_lamp_y <= 1'b0;
                    r_lamp_g <= 1'b0;
                    r_last   <= LL_NONE;
                    r_dwell  <= '0;
                    r_multi  <= '0;
                    r_flash  <= '0;
                end else if (r_flash == '0) begin
                    r_flash  <= FLASH_C - 1'b1;
                    r_lamp_y <= ~r_lamp_y;
                end else begin
                    r_flash <= r_flash - 1'b1;
                end
            end
        end
    end

    assign lamp_r = r_lamp_r;
    assign lamp_y = r_lamp_y;
    assign lamp_g = r_lamp_g;
    assign fault  = r_fault;

endmodule
